// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder.
// Contains the bus types, the default I/O window addresses and the
// halt request encodings driven to the CPU pipeline.
package cpu_mem_responder_pkg;

  typedef logic [7:0]  byte_bus_t;
  typedef logic [17:0] ram_addr_bus_t;

  localparam ram_addr_bus_t IO_TX_ADDR_DEF   = 18'h30000;
  localparam ram_addr_bus_t IO_DONE_ADDR_DEF = 18'h30004;

  typedef enum logic [1:0] {
    HaltNone = 2'b00,
    HaltAll  = 2'b11
  } halt_e;

endpackage

// File: rtl/cpu_mem_responder_io_tx_fifo.sv
// io_tx_fifo: circular byte FIFO for the TX I/O window.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write request and byte; accepted when not full or when
//                   a pop frees a slot in the same cycle
//   pop             remove the head byte (ignored when empty)
//   head            head byte, combinational; reads 0 while empty
//   count           number of stored bytes (0..DEPTH)
//   full, empty     status flags
module io_tx_fifo
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  byte_bus_t                push_data,
  input  logic                     pop,
  output byte_bus_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  byte_bus_t   mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the CPU byte bus.
// Byte RAM at 0..RAM_DEPTH-1 plus an I/O window with a TX FIFO and a
// simulation-done register. Reads have a fixed 1-cycle latency.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_ce_i, cpu_wr_i       bus enable, 1 = write / 0 = read
//   cpu_addr_i, cpu_data_i   byte address and write data
//   cpu_data_o               registered read data
//   halt_req_o               2'b11 freezes the CPU while TX is almost full
//   io_tx_data_o/valid_o     FIFO head byte / FIFO not empty
//   io_tx_ready_i            sink takes the head byte this cycle
//   sim_done_o, overflow_o   sticky status flags
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH   = 18,
  parameter int unsigned            RAM_DEPTH    = 131072,
  parameter logic [ADDR_WIDTH-1:0]  IO_TX_ADDR   = IO_TX_ADDR_DEF,
  parameter logic [ADDR_WIDTH-1:0]  IO_DONE_ADDR = IO_DONE_ADDR_DEF,
  parameter int unsigned            FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic                  cpu_wr_i,
  input  logic [7:0]            cpu_data_i,
  output logic [7:0]            cpu_data_o,
  output logic [1:0]            halt_req_o,
  output logic [7:0]            io_tx_data_o,
  output logic                  io_tx_valid_o,
  input  logic                  io_tx_ready_i,
  output logic                  sim_done_o,
  output logic                  overflow_o
);

  localparam int unsigned RAW = $clog2(RAM_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  byte_bus_t     ram [RAM_DEPTH];
  logic          is_ram;
  logic          is_tx;
  logic          is_done;
  logic          rd_en;
  logic          wr_en;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic          push_ok;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] next_count;
  byte_bus_t     rd_data;
  halt_e         halt_q;
  logic          done_q;
  logic          ovf_q;

  always_comb begin
    is_ram  = 32'(cpu_addr_i) < RAM_DEPTH;
    is_tx   = (cpu_addr_i == IO_TX_ADDR);
    is_done = (cpu_addr_i == IO_DONE_ADDR);
    rd_en   = cpu_ce_i && !cpu_wr_i;
    wr_en   = cpu_ce_i && cpu_wr_i;
  end

  always_comb begin
    rd_data = '0;
    if (is_ram)       rd_data = ram[cpu_addr_i[RAW-1:0]];
    else if (is_tx)   rd_data = 8'(tx_count);
    else if (is_done) rd_data = {7'b0, done_q};
  end

  assign tx_push = wr_en && is_tx;
  assign tx_pop  = io_tx_valid_o && io_tx_ready_i;
  // Mirrors the FIFO's own acceptance rule so halt can look one cycle ahead.
  assign push_ok    = tx_push && (!tx_full || tx_pop);
  assign next_count = tx_count + CW'(push_ok) - CW'(tx_pop);

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (cpu_data_i),
    .pop       (tx_pop),
    .head      (io_tx_data_o),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram[cpu_addr_i[RAW-1:0]] <= cpu_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_data_o <= '0;
      halt_q     <= HaltNone;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (rd_en) cpu_data_o <= rd_data;
      // Almost-full threshold leaves room for one write already on the bus.
      halt_q <= (next_count >= CW'(FIFO_DEPTH - 1)) ? HaltAll : HaltNone;
      if (wr_en && is_done) done_q <= 1'b1;
      if (tx_push && tx_full && !tx_pop) ovf_q <= 1'b1;
    end
  end

  assign halt_req_o    = halt_q;
  assign io_tx_valid_o = !tx_empty;
  assign sim_done_o    = done_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  localparam logic [17:0] TX_A   = 18'h30000;
  localparam logic [17:0] DONE_A = 18'h30004;
  localparam int          DEPTH  = 8;
  localparam int          RAMD   = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [17:0] cpu_addr_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  cpu_data_o;
  logic [1:0]  halt_req_o;
  logic [7:0]  io_tx_data_o;
  logic        io_tx_valid_o;
  logic        io_tx_ready_i;
  logic        sim_done_o;
  logic        overflow_o;

  cpu_mem_responder #(
    .ADDR_WIDTH   (18),
    .RAM_DEPTH    (RAMD),
    .IO_TX_ADDR   (TX_A),
    .IO_DONE_ADDR (DONE_A),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_ce_i      (cpu_ce_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wr_i      (cpu_wr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_data_o    (cpu_data_o),
    .halt_req_o    (halt_req_o),
    .io_tx_data_o  (io_tx_data_o),
    .io_tx_valid_o (io_tx_valid_o),
    .io_tx_ready_i (io_tx_ready_i),
    .sim_done_o    (sim_done_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] tx_q [$];     // model FIFO contents, advanced at each edge
  logic [7:0] exp_tx [$];   // scoreboard of bytes the sink must see
  logic [7:0] exp_rd [$];   // scoreboard of read results
  logic [7:0] exp_last = 8'h00;
  logic       m_done = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_halt = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of what happens on one rising edge, from the bus rules.
  task automatic model_edge();
    logic [7:0] rv;
    if (cpu_ce_i && !cpu_wr_i) begin
      if (int'(cpu_addr_i) < RAMD) rv = ram_m[int'(cpu_addr_i)];
      else if (cpu_addr_i == TX_A) rv = 8'(tx_q.size());
      else if (cpu_addr_i == DONE_A) rv = {7'b0, m_done};
      else rv = 8'h00;
      exp_rd.push_back(rv);
    end
    if (io_tx_ready_i && tx_q.size() > 0) void'(tx_q.pop_front());
    if (cpu_ce_i && cpu_wr_i) begin
      if (int'(cpu_addr_i) < RAMD) ram_m[int'(cpu_addr_i)] = cpu_data_i;
      else if (cpu_addr_i == TX_A) begin
        if (tx_q.size() < DEPTH) begin
          tx_q.push_back(cpu_data_i);
          exp_tx.push_back(cpu_data_i);
        end else m_ovf = 1'b1;
      end else if (cpu_addr_i == DONE_A) m_done = 1'b1;
    end
    m_halt = (tx_q.size() >= DEPTH - 1);
  endtask

  task automatic cycle(input logic ce, input logic wr, input logic [17:0] addr,
                       input logic [7:0] data, input logic rdy);
    cpu_ce_i = ce; cpu_wr_i = wr; cpu_addr_i = addr; cpu_data_i = data; io_tx_ready_i = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && tx_q.size() != 0; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scoreboards on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("halt", 8'(halt_req_o), m_halt ? 8'h03 : 8'h00);
      check("sim_done", 8'(sim_done_o), 8'(m_done));
      check("overflow", 8'(overflow_o), 8'(m_ovf));
      check("tx_valid", 8'(io_tx_valid_o), 8'(exp_tx.size() != 0));
      if (exp_rd.size() != 0) exp_last = exp_rd.pop_front();
      check("rdata", cpu_data_o, exp_last);
      if (io_tx_valid_o && io_tx_ready_i) begin
        if (exp_tx.size() == 0) check("tx_unexpected", io_tx_data_o, 8'hxx);
        else check("tx_data", io_tx_data_o, exp_tx.pop_front());
      end
    end
  end

  initial begin
    logic [17:0] pool [16];
    logic [17:0] unm [4];
    int r;
    rst = 1'b1; cpu_ce_i = 0; cpu_wr_i = 0; cpu_addr_i = '0; cpu_data_i = '0; io_tx_ready_i = 0;
    #3;
    check("rst_rdata", cpu_data_o, 8'h00);
    check("rst_halt", 8'(halt_req_o), 8'h00);
    check("rst_valid", 8'(io_tx_valid_o), 8'h00);
    check("rst_txdata", io_tx_data_o, 8'h00);
    check("rst_done", 8'(sim_done_o), 8'h00);
    check("rst_ovf", 8'(overflow_o), 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read-after-write, unmapped read
    cycle(1, 1, 18'h00010, 8'hA5, 0);
    cycle(1, 0, 18'h00010, 8'h00, 0);
    cycle(1, 0, 18'h2FFFF, 8'h00, 0);
    cycle(0, 0, '0, '0, 0);

    // Back-to-back reads
    cycle(1, 1, 18'h0, 8'h11, 0);
    cycle(1, 1, 18'h1, 8'h22, 0);
    cycle(1, 1, 18'h2, 8'h33, 0);
    cycle(1, 0, 18'h0, 8'h00, 0);
    cycle(1, 0, 18'h1, 8'h00, 0);
    cycle(1, 0, 18'h2, 8'h00, 0);
    cycle(0, 0, '0, '0, 0);

    // Fill to almost-full, full, then overflow
    for (int i = 1; i <= 7; i++) cycle(1, 1, TX_A, 8'(i), 0);
    cycle(1, 0, TX_A, '0, 0);
    cycle(1, 1, TX_A, 8'd8, 0);
    cycle(1, 0, TX_A, '0, 0);
    cycle(1, 1, TX_A, 8'd9, 0);
    cycle(1, 0, TX_A, '0, 0);
    drain();

    // Simultaneous push/pop with three bytes resident, wrapping the pointers
    for (int i = 0; i < 3; i++) cycle(1, 1, TX_A, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 12; i++) cycle(1, 1, TX_A, 8'h50 + 8'(i), 1);
    cycle(1, 0, TX_A, '0, 0);
    drain();

    // Sim-done register
    cycle(1, 1, DONE_A, 8'h5A, 0);
    cycle(1, 0, DONE_A, '0, 0);
    cycle(0, 0, '0, '0, 0);

    // Asynchronous reset mid-stream with full FIFO, overflow and a pending read
    for (int i = 0; i < 9; i++) cycle(1, 1, TX_A, 8'hC0 + 8'(i), 0);
    cycle(1, 0, 18'h00010, '0, 0);
    cpu_ce_i = 0;
    rst = 1'b1;
    #2;
    check("arst_rdata", cpu_data_o, 8'h00);
    check("arst_halt", 8'(halt_req_o), 8'h00);
    check("arst_valid", 8'(io_tx_valid_o), 8'h00);
    check("arst_txdata", io_tx_data_o, 8'h00);
    check("arst_done", 8'(sim_done_o), 8'h00);
    check("arst_ovf", 8'(overflow_o), 8'h00);
    tx_q.delete(); exp_tx.delete(); exp_rd.delete();
    exp_last = 8'h00; m_done = 0; m_ovf = 0; m_halt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic
    pool[0] = 18'h1FFFF;
    for (int i = 1; i < 16; i++) pool[i] = 18'($urandom_range(0, 32'h1FFFE));
    unm[0] = 18'h20000; unm[1] = 18'h2FFFF; unm[2] = 18'h3FFFF; unm[3] = 18'h30001;
    for (int i = 0; i < 16; i++) cycle(1, 1, pool[i], 8'($urandom), 0);
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      rdy = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 11);
      if (r < 3)       cycle(1, 1, pool[$urandom_range(0, 15)], 8'($urandom), rdy);
      else if (r < 6)  cycle(1, 0, pool[$urandom_range(0, 15)], '0, rdy);
      else if (r < 8)  cycle(1, 1, TX_A, 8'($urandom), rdy);
      else if (r == 8) cycle(1, 0, TX_A, '0, rdy);
      else if (r == 9) cycle(1, $urandom_range(0, 5) == 0, DONE_A, '0, rdy);
      else if (r == 10) cycle(1, 1'($urandom), unm[$urandom_range(0, 3)], 8'($urandom), rdy);
      else             cycle(0, 1'($urandom), 18'($urandom), 8'($urandom), rdy);
    end
    drain();
    cycle(0, 0, '0, '0, 0);
    check("tx_leftover", 8'(exp_tx.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
